// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit accumulator CPU: opcode encoding and sequencer states.
package cpu_pkg;

    localparam int INSTR_W = 8;

    typedef enum logic [3:0] {
        OP_HLT = 4'h0,
        OP_SKZ = 4'h1,
        OP_ADD = 4'h2,
        OP_AND = 4'h3,
        OP_XOR = 4'h4,
        OP_LDA = 4'h5,
        OP_STO = 4'h6,
        OP_JMP = 4'h7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_HALT   = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR and the shared memory port.
//
// state  | meaning
// IDLE   | waiting for run_i
// FETCH  | instruction read at pc, held until ack
// DECODE | one cycle, opcode dispatch, is_zero_i sampled
// READ   | operand read, accumulator loads in the ack cycle
// WRITE  | accumulator written to operand address
// HALT   | HLT executed, sticky until reset
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_i,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ack_i,
    input  logic              is_zero_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              acc_load_o,
    output logic [3:0]        alu_opcode_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o,
    output logic [2:0]        state_o
);

    ctrl_state_e         state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   operand;
    logic [INSTR_W-1:0]  ir;

    assign pc_inc  = pc + ADDR_W'(1);
    assign operand = ADDR_W'(ir[3:0]);

    assign acc_load_o   = (state == ST_READ) && mem_ack_i;
    assign alu_opcode_o = ir[7:4];
    assign pc_o         = pc;
    assign state_o      = state;

    // Request, direction and address are registered on entry to a memory state,
    // so they are stable from the first request cycle through the ack cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            ir         <= '0;
            mem_req_o  <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= '0;
            halted_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run_i) begin
                        state      <= ST_FETCH;
                        mem_req_o  <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= pc;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack_i) begin
                        ir        <= mem_rdata_i;
                        pc        <= pc_inc;
                        mem_req_o <= 1'b0;
                        state     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state      <= ST_FETCH;
                    mem_req_o  <= 1'b1;
                    mem_we_o   <= 1'b0;
                    mem_addr_o <= pc;
                    case (ir[7:4])
                        OP_HLT: begin
                            state     <= ST_HALT;
                            mem_req_o <= 1'b0;
                            halted_o  <= 1'b1;
                        end
                        OP_SKZ: begin
                            if (is_zero_i) begin
                                pc         <= pc_inc;
                                mem_addr_o <= pc_inc;
                            end
                        end
                        OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                            state      <= ST_READ;
                            mem_addr_o <= operand;
                        end
                        OP_STO: begin
                            state      <= ST_WRITE;
                            mem_we_o   <= 1'b1;
                            mem_addr_o <= operand;
                        end
                        OP_JMP: begin
                            pc         <= operand;
                            mem_addr_o <= operand;
                        end
                        default: ;
                    endcase
                end
                ST_READ, ST_WRITE: begin
                    // Request stays up: the next fetch follows back-to-back.
                    if (mem_ack_i) begin
                        state      <= ST_FETCH;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= pc;
                    end
                end
                ST_HALT: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: memory/accumulator environment, ISA-level reference model, scoreboard.
module tb_cpu_control_fsm;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run_i = 1'b0;
    logic [7:0]    mem_rdata_i = 8'h00;
    logic          mem_ack_i = 1'b0;
    logic          is_zero_i;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic          acc_load_o;
    logic [3:0]    alu_opcode_o;
    logic [AW-1:0] pc_o;
    logic          halted_o;
    logic [2:0]    state_o;

    cpu_control_fsm #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run_i        (run_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .is_zero_i    (is_zero_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .acc_load_o   (acc_load_o),
        .alu_opcode_o (alu_opcode_o),
        .pc_o         (pc_o),
        .halted_o     (halted_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic       load;
        logic [3:0] op;
        logic [7:0] wdata;
    } txn_t;

    int   tests = 0;
    int   fails = 0;
    txn_t exp_q[$];
    bit   model_halted = 0;
    int   load_cnt = 0;

    logic [7:0] mem [256];
    logic [7:0] acc;
    int         force_wait = -1;
    int         wait_max = 2;
    int         wait_left = 0;
    bit         new_txn = 1;

    function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'h2:    return a + b;
            4'h3:    return a & b;
            4'h4:    return a ^ b;
            4'h5:    return b;
            default: return a;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Datapath stand-in: accumulator and zero flag
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= 8'h00;
        else if (acc_load_o) acc <= alu(alu_opcode_o, acc, mem_rdata_i);
    end
    assign is_zero_i = (acc == 8'h00);

    // Memory responder with random (or forced) wait states
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mem_ack_i = 1'b0;
            if (rst_n && mem_req_o) begin
                if (new_txn) begin
                    wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, wait_max));
                    new_txn = 0;
                end
                if (wait_left == 0) begin
                    mem_ack_i = 1'b1;
                    if (mem_we_o) mem[mem_addr_o] = acc;
                    else mem_rdata_i = mem[mem_addr_o];
                    new_txn = 1;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Monitor: every completed memory transaction is checked against the scoreboard
    initial begin
        txn_t act, e;
        forever begin
            @(negedge clk);
            if (rst_n && acc_load_o) load_cnt++;
            if (rst_n && acc_load_o && !(mem_req_o && mem_ack_i && !mem_we_o))
                check("acc_load_outside_read", 1, 0);
            if (rst_n && mem_req_o && mem_ack_i) begin
                act.we    = mem_we_o;
                act.addr  = mem_addr_o;
                act.load  = acc_load_o;
                act.op    = acc_load_o ? alu_opcode_o : 4'h0;
                act.wdata = mem_we_o ? acc : 8'h00;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("mem_txn", act, e);
                end else if (model_halted) begin
                    check("unexpected_txn", act, 0);
                end
            end
        end
    end

    // Instruction-level reference: executes the program in mem and queues the memory traffic
    task automatic run_model(input int max_instr);
        logic [7:0] rmem [256];
        logic [7:0] rpc, racc, instr, opd;
        txn_t t;
        for (int i = 0; i < 256; i++) rmem[i] = mem[i];
        rpc = 0;
        racc = 0;
        model_halted = 0;
        for (int n = 0; n < max_instr; n++) begin
            exp_q.push_back('{we: 1'b0, addr: rpc, load: 1'b0, op: 4'h0, wdata: 8'h00});
            instr = rmem[rpc];
            rpc = rpc + 8'd1;
            opd = {4'h0, instr[3:0]};
            if (instr[7:4] == 4'h0) begin
                model_halted = 1;
                break;
            end else if (instr[7:4] == 4'h1) begin
                if (racc == 0) rpc = rpc + 8'd1;
            end else if (instr[7:4] >= 4'h2 && instr[7:4] <= 4'h5) begin
                t = '{we: 1'b0, addr: opd, load: 1'b1, op: instr[7:4], wdata: 8'h00};
                exp_q.push_back(t);
                racc = alu(instr[7:4], racc, rmem[opd]);
            end else if (instr[7:4] == 4'h6) begin
                exp_q.push_back('{we: 1'b1, addr: opd, load: 1'b0, op: 4'h0, wdata: racc});
                rmem[opd] = racc;
            end else if (instr[7:4] == 4'h7) begin
                rpc = opd;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ack_i = 1'b0;
        new_txn = 1;
        exp_q.delete();
        model_halted = 0;
        load_cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_run();
        @(negedge clk);
        run_i = 1'b1;
        @(negedge clk);
        run_i = 1'b0;
    endtask

    task automatic run_prog(input string name, input int max_instr, input int fw);
        int cyc;
        int req_cnt;
        do_reset();
        force_wait = fw;
        run_model(max_instr);
        pulse_run();
        cyc = 0;
        while (exp_q.size() > 0 && cyc < max_instr * 10 + 50) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_timeout"}, exp_q.size(), 0);
        if (model_halted) begin
            repeat (2) @(negedge clk);
            check({name, "_halted"}, halted_o, 1);
            run_i = 1'b1;
            req_cnt = 0;
            repeat (20) begin
                @(negedge clk);
                if (mem_req_o) req_cnt++;
            end
            run_i = 1'b0;
            check({name, "_no_req_after_halt"}, req_cnt, 0);
            check({name, "_halt_state"}, state_o, 5);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;

        // Asynchronous reset while a fetch is pending
        do_reset();
        force_wait = 10;
        pulse_run();
        @(negedge clk);
        check("req_before_reset", mem_req_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req", mem_req_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_state", state_o, 0);
        check("rst_halted", halted_o, 0);
        check("rst_alu_opcode", alu_opcode_o, 0);

        // Fetch with three wait states
        do_reset();
        force_wait = 3;
        pulse_run();
        for (int i = 0; i < 4; i++) begin
            check("wait_req", mem_req_o, 1);
            check("wait_addr", mem_addr_o, 0);
            check("wait_we", mem_we_o, 0);
            @(negedge clk);
        end
        check("wait_pc_after_ack", pc_o, 1);
        check("wait_state_decode", state_o, 2);

        // ADD then HLT, zero-wait
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
        mem[0] = 8'h2A; mem[1] = 8'h00; mem[10] = 8'h05;
        run_prog("add", 10, 0);
        check("add_load_count", load_cnt, 1);

        // SKZ taken (acc == 0)
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
        mem[0] = 8'h10; mem[1] = 8'h00; mem[2] = 8'h00;
        run_prog("skz_taken", 10, 0);
        check("skz_taken_pc", pc_o, 3);

        // SKZ not taken (acc loaded non-zero)
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
        mem[0] = 8'h5F; mem[1] = 8'h10; mem[2] = 8'h00; mem[3] = 8'h00; mem[15] = 8'h07;
        run_prog("skz_not_taken", 10, 0);
        check("skz_not_taken_pc", pc_o, 3);

        // JMP then STO
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
        mem[0] = 8'h7C; mem[12] = 8'h63; mem[13] = 8'h00;
        run_prog("jmp_sto", 10, 0);
        check("jmp_sto_mem3", mem[3], 8'h00);

        // Fetch increment wraps 255 -> 0; STO at 0 turns address 0 into HLT
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
        mem[0] = 8'h60;
        run_prog("wrap_fetch", 300, 0);
        check("wrap_fetch_pc", pc_o, 1);

        // SKZ skip wraps 255 -> 0
        for (int i = 0; i < 256; i++) mem[i] = 8'h80;
        mem[0] = 8'h60; mem[254] = 8'h10;
        run_prog("wrap_skz", 300, 0);
        check("wrap_skz_pc", pc_o, 1);

        // Random programs with random wait states
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom_range(0, 255));
                if (mem[i][7:4] == 4'h0) mem[i] = 8'($urandom_range(0, 255));
            end
            run_prog("random", 40, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
